// File: rtl/match_event_counter.sv
// Counts match episodes from the sequence detector, measures each episode's length,
// tracks the longest one and raises a sticky interrupt at a programmable episode count.
module match_event_counter #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       i_match,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic             i_irq_ack,
  output logic [CNT_W-1:0] o_event_cnt,
  output logic [RUN_W-1:0] o_run_len,
  output logic [RUN_W-1:0] o_last_run,
  output logic [RUN_W-1:0] o_max_run,
  output logic             o_in_run,
  output logic             o_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [RUN_W-1:0] last_q, last_d;
  logic [RUN_W-1:0] max_q, max_d;
  logic             irq_q, irq_d;

  logic             match;
  logic             irq_set;
  logic [CNT_W-1:0] evt_inc;

  assign match   = |i_match;
  assign evt_inc = evt_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      evt_q   <= '0;
      run_q   <= '0;
      last_q  <= '0;
      max_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      run_q   <= run_d;
      last_q  <= last_d;
      max_q   <= max_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    evt_d   = evt_q;
    run_d   = run_q;
    last_d  = last_q;
    max_d   = max_q;
    irq_set = 1'b0;

    if (i_clr) begin
      state_d = IDLE;
      evt_d   = '0;
      run_d   = '0;
      last_d  = '0;
      max_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          run_d = '0;
          if (match) begin
            state_d = RUN;
            run_d   = {{(RUN_W-1){1'b0}}, 1'b1};
            // A saturated count does not increment, so it can never re-fire the interrupt.
            if (evt_q != CNT_MAX) begin
              evt_d   = evt_inc;
              irq_set = (i_thresh != '0) && (evt_inc == i_thresh);
            end
          end
        end
        RUN: begin
          if (match) begin
            if (run_q != RUN_MAX) run_d = run_q + 1'b1;
          end else begin
            state_d = IDLE;
            last_d  = run_q;
            if (run_q > max_q) max_d = run_q;
            run_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (i_clr)          irq_d = 1'b0;
    else if (irq_set)   irq_d = 1'b1;
    else if (i_irq_ack) irq_d = 1'b0;
    else                irq_d = irq_q;
  end

  assign o_event_cnt = evt_q;
  assign o_run_len   = run_q;
  assign o_last_run  = last_q;
  assign o_max_run   = max_q;
  assign o_in_run    = (state_q == RUN);
  assign o_irq       = irq_q;

endmodule

// File: tb/tb_match_event_counter.sv
// Directed self-checking bench for match_event_counter: inputs change on the falling
// edge, outputs are checked on the following falling edge.
module tb_match_event_counter;

  logic       clk;
  logic       rstn;
  logic [1:0] i_match;
  logic       i_clr;
  logic [7:0] i_thresh;
  logic       i_irq_ack;
  logic [7:0] o_event_cnt;
  logic [7:0] o_run_len;
  logic [7:0] o_last_run;
  logic [7:0] o_max_run;
  logic       o_in_run;
  logic       o_irq;

  int checks = 0;
  int errors = 0;

  match_event_counter #(.CNT_W(8), .RUN_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_match    (i_match),
    .i_clr      (i_clr),
    .i_thresh   (i_thresh),
    .i_irq_ack  (i_irq_ack),
    .o_event_cnt(o_event_cnt),
    .o_run_len  (o_run_len),
    .o_last_run (o_last_run),
    .o_max_run  (o_max_run),
    .o_in_run   (o_in_run),
    .o_irq      (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive i_match for n cycles and land on the falling edge after the last sampling edge.
  task automatic applyStimulus(input logic [1:0] m, input int n);
    for (int k = 0; k < n; k++) begin
      i_match = m;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " cnt"},    32'(o_event_cnt), 0);
    checkOutput({tag, " run"},    32'(o_run_len),   0);
    checkOutput({tag, " last"},   32'(o_last_run),  0);
    checkOutput({tag, " max"},    32'(o_max_run),   0);
    checkOutput({tag, " in_run"}, 32'(o_in_run),    0);
    checkOutput({tag, " irq"},    32'(o_irq),       0);
  endtask

  task automatic episode();
    applyStimulus(2'b01, 1);
    applyStimulus(2'b00, 1);
  endtask

  initial begin
    rstn      = 1'b0;
    i_match   = 2'b01;
    i_clr     = 1'b0;
    i_thresh  = 8'd0;
    i_irq_ack = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    i_match = 2'b00;
    rstn    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b00, 1);
      checkOutput("idle cnt", 32'(o_event_cnt), 0);
      checkOutput("idle in_run", 32'(o_in_run), 0);
    end
    checkAllZero("idle end");

    // Run-length capture: 3, gap 2, 5, gap 1, 2
    applyStimulus(2'b01, 1);
    checkOutput("run1 cnt", 32'(o_event_cnt), 1);
    checkOutput("run1 len", 32'(o_run_len), 1);
    checkOutput("run1 in_run", 32'(o_in_run), 1);
    applyStimulus(2'b10, 2);
    checkOutput("run1 len3", 32'(o_run_len), 3);
    applyStimulus(2'b00, 1);
    checkOutput("run1 last", 32'(o_last_run), 3);
    checkOutput("run1 max", 32'(o_max_run), 3);
    checkOutput("run1 fall len", 32'(o_run_len), 0);
    checkOutput("run1 fall in_run", 32'(o_in_run), 0);
    applyStimulus(2'b00, 1);
    applyStimulus(2'b11, 5);
    checkOutput("run2 cnt", 32'(o_event_cnt), 2);
    checkOutput("run2 len", 32'(o_run_len), 5);
    applyStimulus(2'b00, 1);
    checkOutput("run2 last", 32'(o_last_run), 5);
    checkOutput("run2 max", 32'(o_max_run), 5);
    applyStimulus(2'b01, 2);
    applyStimulus(2'b00, 1);
    checkOutput("run3 cnt", 32'(o_event_cnt), 3);
    checkOutput("run3 last", 32'(o_last_run), 2);
    checkOutput("run3 max", 32'(o_max_run), 5);
    checkOutput("run3 len", 32'(o_run_len), 0);

    // Back-to-back 1,0,1 counts two episodes
    i_clr = 1'b1;
    applyStimulus(2'b00, 1);
    i_clr = 1'b0;
    checkAllZero("clear");
    applyStimulus(2'b01, 1);
    applyStimulus(2'b00, 1);
    applyStimulus(2'b01, 1);
    checkOutput("b2b cnt", 32'(o_event_cnt), 2);
    checkOutput("b2b last", 32'(o_last_run), 1);

    // Interrupt at threshold 3
    i_clr    = 1'b1;
    applyStimulus(2'b00, 1);
    i_clr    = 1'b0;
    i_thresh = 8'd3;
    episode();
    episode();
    checkOutput("irq before", 32'(o_irq), 0);
    applyStimulus(2'b01, 1);
    checkOutput("irq thr cnt", 32'(o_event_cnt), 3);
    checkOutput("irq thr set", 32'(o_irq), 1);
    applyStimulus(2'b00, 1);
    episode();
    checkOutput("irq ep4 cnt", 32'(o_event_cnt), 4);
    checkOutput("irq ep4 sticky", 32'(o_irq), 1);
    i_irq_ack = 1'b1;
    applyStimulus(2'b00, 1);
    i_irq_ack = 1'b0;
    checkOutput("irq ack", 32'(o_irq), 0);
    episode();
    checkOutput("irq ep5 cnt", 32'(o_event_cnt), 5);
    checkOutput("irq ep5", 32'(o_irq), 0);
    i_thresh  = 8'd6;
    i_irq_ack = 1'b1;
    applyStimulus(2'b01, 1);
    i_irq_ack = 1'b0;
    checkOutput("irq set+ack cnt", 32'(o_event_cnt), 6);
    checkOutput("irq set+ack", 32'(o_irq), 1);
    i_irq_ack = 1'b1;
    applyStimulus(2'b00, 1);
    i_irq_ack = 1'b0;
    i_thresh  = 8'd4;
    applyStimulus(2'b00, 2);
    checkOutput("irq no retro", 32'(o_irq), 0);

    // Clear mid-run is not captured; held match starts a fresh episode
    i_thresh = 8'd0;
    i_clr    = 1'b1;
    applyStimulus(2'b00, 1);
    i_clr    = 1'b0;
    applyStimulus(2'b01, 4);
    checkOutput("clrrun len", 32'(o_run_len), 4);
    i_clr = 1'b1;
    applyStimulus(2'b01, 1);
    i_clr = 1'b0;
    checkAllZero("clrrun");
    applyStimulus(2'b01, 1);
    checkOutput("clrrun new cnt", 32'(o_event_cnt), 1);
    checkOutput("clrrun new len", 32'(o_run_len), 1);
    checkOutput("clrrun new in_run", 32'(o_in_run), 1);
    checkOutput("clrrun last", 32'(o_last_run), 0);

    // Saturation of the episode counter and threshold 255
    i_clr    = 1'b1;
    applyStimulus(2'b00, 1);
    i_clr    = 1'b0;
    i_thresh = 8'd255;
    for (int i = 0; i < 254; i++) episode();
    checkOutput("sat 254 irq", 32'(o_irq), 0);
    episode();
    checkOutput("sat 255 cnt", 32'(o_event_cnt), 255);
    checkOutput("sat 255 irq", 32'(o_irq), 1);
    i_irq_ack = 1'b1;
    applyStimulus(2'b00, 1);
    i_irq_ack = 1'b0;
    checkOutput("sat ack", 32'(o_irq), 0);
    for (int i = 0; i < 5; i++) episode();
    checkOutput("sat 260 cnt", 32'(o_event_cnt), 255);
    checkOutput("sat 260 irq", 32'(o_irq), 0);

    // Run-length saturation
    applyStimulus(2'b01, 300);
    checkOutput("runsat len", 32'(o_run_len), 255);
    checkOutput("runsat in_run", 32'(o_in_run), 1);
    applyStimulus(2'b00, 1);
    checkOutput("runsat last", 32'(o_last_run), 255);
    checkOutput("runsat max", 32'(o_max_run), 255);
    checkOutput("runsat len0", 32'(o_run_len), 0);

    // Asynchronous reset between edges while in RUN with irq set
    i_clr    = 1'b1;
    applyStimulus(2'b00, 1);
    i_clr    = 1'b0;
    i_thresh = 8'd1;
    applyStimulus(2'b01, 2);
    checkOutput("async pre irq", 32'(o_irq), 1);
    checkOutput("async pre len", 32'(o_run_len), 2);
    #2;
    rstn = 1'b0;
    #1;
    checkAllZero("async");
    @(negedge clk);
    rstn = 1'b1;
    applyStimulus(2'b01, 1);
    checkOutput("post rst cnt", 32'(o_event_cnt), 1);
    checkOutput("post rst len", 32'(o_run_len), 1);
    checkOutput("post rst irq", 32'(o_irq), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/match_event_counter.md
# match_event_counter

Downstream consumer of the sequence-detector Moore FSM. It takes the detector's 2-bit match output and counts match episodes, measures each episode's length in cycles, and tracks the longest one. It raises a sticky interrupt when the episode count reaches a programmable threshold. Results go to a register/status interface; all logic runs in the detector's clock domain.

## Interface
Parameters:
- CNT_W, 8, width of the episode counter and threshold
- RUN_W, 8, width of the run-length counters

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  reset, asynchronous, active-low
- i_match  input  2  detector output; match = |i_match
- i_clr  input  1  synchronous clear of all counters, flags and FSM
- i_thresh  input  CNT_W  episode count that triggers o_irq; 0 disables the interrupt
- i_irq_ack  input  1  one-cycle pulse that clears o_irq
- o_event_cnt  output  CNT_W  number of match episodes (rising edges of match), saturating
- o_run_len  output  RUN_W  live length of the current episode; 0 in IDLE
- o_last_run  output  RUN_W  length of the most recently completed episode
- o_max_run  output  RUN_W  longest completed episode since reset/clear
- o_in_run  output  1  high while FSM is in RUN
- o_irq  output  1  sticky threshold interrupt

## Operation
- FSM states: IDLE (2'b00) and RUN (2'b01). Encodings 2'b10 and 2'b11 are illegal and go to IDLE on the next edge with no counter update.
- IDLE, match=1: go to RUN; o_event_cnt += 1 (saturates at 2^CNT_W-1); o_run_len <= 1.
- IDLE, match=0: stay; o_run_len holds 0.
- RUN, match=1: stay; o_run_len += 1, saturating at 2^RUN_W-1.
- RUN, match=0: go to IDLE; o_last_run <= o_run_len; o_max_run <= max(o_max_run, o_run_len); o_run_len <= 0.
- Interrupt set condition: i_thresh != 0 and the IDLE->RUN increment makes the new count equal i_thresh. If o_event_cnt is already saturated, no increment occurs and o_irq is not set.
- o_irq is cleared by i_irq_ack. If set and ack happen in the same cycle, set wins and o_irq stays 1. Changing i_thresh never sets o_irq retroactively.
- i_clr has the highest priority. It zeroes all counters, o_last_run, o_max_run and o_irq, and forces IDLE. A clear issued during RUN does not capture the run. If match is still 1 after the clear, the next cycle counts as a new episode.
- o_in_run = (state == RUN).
- All outputs are driven directly from registers; there is no combinational path from input to output.

## Timing
- Reset (rstn=0, asynchronous): state IDLE; o_event_cnt, o_run_len, o_last_run, o_max_run = 0; o_irq = 0; o_in_run = 0.
- Latency is 1 cycle. If match is seen at edge N, o_event_cnt, o_run_len=1 and o_in_run are visible after edge N.
- A match lasting K consecutive sampled cycles gives o_run_len = K and o_last_run = K after the first edge sampling match=0.
- o_irq asserts at the same edge that o_event_cnt becomes i_thresh.
- Back-to-back episodes (1,0,1) count as 2 episodes; o_last_run = 1.
- Reset released mid-stream with match=1 counts as a new episode on the first active edge.

## Test plan
- Reset and idle: hold rstn=0, drive i_match=2'b01, then release with i_match=0 for 10 cycles -> all outputs 0 throughout, o_in_run=0.
- Run-length capture: match for runs of 3, 0-gap 2, 5, 0-gap 1, 2 cycles -> o_event_cnt=3, o_last_run=2, o_max_run=5, o_run_len=0 after the final fall.
- Interrupt: i_thresh=3, generate 4 episodes -> o_irq rises on the edge where o_event_cnt=3 and stays set through episode 4. Ack -> o_irq=0. Then a 5th episode -> o_irq stays 0. Also set i_thresh=6 and pulse ack in the same cycle as the 6th episode's set -> o_irq=1.
- Saturation: CNT_W=8 with 260 episodes -> o_event_cnt=255. A 300-cycle run with RUN_W=8 -> o_run_len=255 and o_last_run=255. i_thresh=255 -> o_irq set once, not re-set by the saturated episodes.
- Clear mid-run: in RUN with o_run_len=4, pulse i_clr while match stays 1 -> next edge all counters 0 and IDLE; the edge after that o_event_cnt=1, o_run_len=1. o_last_run stays 0 (run not captured).
- Async reset mid-run: assert rstn=0 between clock edges during RUN with o_irq=1 -> all outputs 0 immediately, without waiting for a clock edge.
